vga_scan_controller: RTL and testbench

VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_gen.sv | 41 ++++
 rtl/vga_scan_controller.sv | 113 +++++++++++
 tb/tb_vga_scan_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, counter width and scan FSM encoding for the VGA scan controller.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BP     = 248;
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 38;

  localparam int CNT_W = 13;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESYNC = 2'd2
  } scan_state_t;

  // Increment with wrap at total-1; shared by the line counter and the load-line lookahead.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v, input int total);
    return (v == CNT_W'(total - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational active/sync decode at the counter position.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             iCLK,
  input  logic             iRST,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs,
  output logic             vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // v_cnt resets to the last line so the first line scanned after reset is the one that loads line 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      h_cnt <= '0;
      v_cnt <= CNT_W'(V_TOTAL - 1);
    end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= wrap_inc(v_cnt, V_TOTAL);
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs     = (h_cnt >= CNT_W'(H_ACTIVE + H_FP)) && (h_cnt < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs     = (v_cnt >= CNT_W'(V_ACTIVE + V_FP)) && (v_cnt < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scan_controller.sv
// Scan controller: pulls grayscale pixels from a show-ahead FIFO, requests line loads, flushes leftovers each frame.
module vga_scan_controller import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFIFO_EMPTY,
  input  logic [7:0]  iFIFO_RDATA,
  output logic        oFIFO_RDREQ,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oFRAME_DONE,
  output logic        oUNDERFLOW
);

  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] h_cnt, v_cnt, next_line;
  logic             active, hs, vs;
  logic             load_hit, vs_start, frame_wrap;
  logic             rd_req, uf_set;
  logic [7:0]       pix_q;
  scan_state_t      state, state_nxt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs     (hs),
    .vs     (vs)
  );

  assign next_line  = wrap_inc(v_cnt, V_TOTAL);
  assign load_hit   = (h_cnt == CNT_W'(H_ACTIVE)) && (next_line < CNT_W'(V_ACTIVE));
  assign vs_start   = (v_cnt == CNT_W'(V_ACTIVE + V_FP)) && (h_cnt == '0);
  assign frame_wrap = (v_cnt == CNT_W'(V_TOTAL - 1)) && (h_cnt == '0);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    uf_set    = 1'b0;
    unique case (state)
      ST_RUN: begin
        rd_req = active & ~iFIFO_EMPTY;
        uf_set = active & iFIFO_EMPTY;
        if (vs_start) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        rd_req = ~iFIFO_EMPTY;
        // Flush overran the blanking interval: flag it and realign before line 0 loads.
        if (frame_wrap) begin
          uf_set    = 1'b1;
          state_nxt = ST_RUN;
        end else if (iFIFO_EMPTY) begin
          state_nxt = ST_RESYNC;
        end
      end
      ST_RESYNC: if (frame_wrap) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  assign oFIFO_RDREQ = rd_req & ~iRST;
  assign oFRAME_DONE = ~iRST & (v_cnt == CNT_W'(V_ACTIVE)) & (h_cnt == '0);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pix_q                 <= '0;
      oVGA_HS               <= 1'b0;
      oVGA_VS               <= 1'b0;
      oVGA_BLANK_N          <= 1'b0;
      oVGA_LOAD_TO_FIFO_REQ <= 1'b0;
      oVGA_LINE_TO_LOAD     <= '0;
      oUNDERFLOW            <= 1'b0;
    end else begin
      pix_q                 <= (state == ST_RUN && rd_req) ? iFIFO_RDATA : 8'h00;
      oVGA_HS               <= hs;
      oVGA_VS               <= vs;
      oVGA_BLANK_N          <= active;
      oVGA_LOAD_TO_FIFO_REQ <= load_hit;
      if (load_hit) oVGA_LINE_TO_LOAD <= next_line;
      if (uf_set)   oUNDERFLOW        <= 1'b1;
    end
  end

  assign oVGA_R = pix_q;
  assign oVGA_G = pix_q;
  assign oVGA_B = pix_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a scaled-down raster, with a FIFO + line-loader model and a raster-position reference.
module tb_vga_scan_controller;

  localparam int HA = 160, HFP = 8, HSY = 16, HBP = 16;
  localparam int VA = 12,  VFP = 1, VSY = 3,  VBP = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic        iCLK, iRST, iFIFO_EMPTY;
  logic [7:0]  iFIFO_RDATA;
  logic        oFIFO_RDREQ, oVGA_LOAD_TO_FIFO_REQ;
  logic [12:0] oVGA_LINE_TO_LOAD;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFRAME_DONE, oUNDERFLOW;

  int checks = 0, failures = 0;
  int t = 0, fr = -1, extra = 0;
  bit force_en = 0;
  logic [7:0] fifo[$];

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iFIFO_EMPTY(iFIFO_EMPTY), .iFIFO_RDATA(iFIFO_RDATA),
    .oFIFO_RDREQ(oFIFO_RDREQ), .oVGA_LINE_TO_LOAD(oVGA_LINE_TO_LOAD),
    .oVGA_LOAD_TO_FIFO_REQ(oVGA_LOAD_TO_FIFO_REQ), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G),
    .oVGA_B(oVGA_B), .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oFRAME_DONE(oFRAME_DONE), .oUNDERFLOW(oUNDERFLOW)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Raster position p counts clocks since reset release; the scan starts on the last line.
  function automatic int h_of(int p); return p % HT; endfunction
  function automatic int v_of(int p); return (VT - 1 + p / HT) % VT; endfunction
  function automatic bit act(int p); return (h_of(p) < HA) && (v_of(p) < VA); endfunction
  function automatic int nl(int v); return (v + 1) % VT; endfunction
  function automatic bit forced(int p);
    return force_en && v_of(p) == 5 && h_of(p) >= 100 && h_of(p) < 110;
  endfunction
  function automatic logic [7:0] pix(int f, int l, int x);
    int s;
    s = l * HA + x + 17 * f;
    return s[7:0];
  endfunction
  function automatic logic [43:0] outs();
    return {oFIFO_RDREQ, oVGA_LINE_TO_LOAD, oVGA_LOAD_TO_FIFO_REQ, oVGA_R, oVGA_G, oVGA_B,
            oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFRAME_DONE, oUNDERFLOW};
  endfunction

  // One clock: model FIFO pop and line loader at the edge, drive FIFO head after it, return at negedge.
  task automatic step();
    bit rd, rq;
    int ln;
    rd = oFIFO_RDREQ;
    rq = oVGA_LOAD_TO_FIFO_REQ;
    ln = int'(oVGA_LINE_TO_LOAD);
    @(posedge iCLK);
    if (iRST) begin t = 0; fr = -1; end
    else t++;
    if (rd && fifo.size() > 0) void'(fifo.pop_front());
    if (rq && !iRST) begin
      if (ln == 0) fr++;
      for (int x = 0; x < HA; x++) fifo.push_back(pix(fr, ln, x));
      if (ln == VA - 1) for (int x = 0; x < extra; x++) fifo.push_back(8'hA5);
    end
    #1;
    iFIFO_EMPTY = (fifo.size() == 0) || forced(t);
    iFIFO_RDATA = (fifo.size() > 0) ? fifo[0] : 8'h00;
    @(negedge iCLK);
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    step();
    step();
    fifo.delete();
    iFIFO_EMPTY = 1'b1;
    iFIFO_RDATA = 8'h00;
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    step();
    step();
    checks++;
    if (outs() !== 44'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs());
    end
    checks++;
    if (oFRAME_DONE !== 1'b0 || oFIFO_RDREQ !== 1'b0) begin
      failures++;
      $display("FAIL reset_comb got=%b%b exp=00", oFRAME_DONE, oFIFO_RDREQ);
    end
    iRST = 1'b0;
  endtask

  task automatic test_first_request();
    int last_line, pulses, p;
    bit exp_rq;
    do_reset();
    last_line = 0;
    pulses = 0;
    while (t < HT + HA + 3) begin
      step();
      p = t - 1;
      exp_rq = (h_of(p) == HA) && (nl(v_of(p)) < VA);
      if (exp_rq) begin last_line = nl(v_of(p)); pulses++; end
      checks++;
      if (oVGA_LOAD_TO_FIFO_REQ !== exp_rq) begin
        failures++;
        $display("FAIL load_req t=%0d got=%b exp=%b", t, oVGA_LOAD_TO_FIFO_REQ, exp_rq);
      end
      checks++;
      if (oVGA_LINE_TO_LOAD !== 13'(last_line)) begin
        failures++;
        $display("FAIL line_to_load t=%0d got=%0d exp=%0d", t, oVGA_LINE_TO_LOAD, last_line);
      end
      if (t == HA + 1) begin
        checks++;
        if (oVGA_LOAD_TO_FIFO_REQ !== 1'b1 || oVGA_LINE_TO_LOAD !== 13'd0) begin
          failures++;
          $display("FAIL first_req got=%b/%0d exp=1/0", oVGA_LOAD_TO_FIFO_REQ, oVGA_LINE_TO_LOAD);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL req_count got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_pixels();
    int n_ok, p;
    logic [7:0] e;
    do_reset();
    n_ok = 0;
    while (t < 3 * HT + 2) begin
      step();
      p = t - 1;
      e = act(p) ? n_ok[7:0] : 8'h00;
      if (act(p)) n_ok++;
      checks++;
      if ({oVGA_R, oVGA_G, oVGA_B} !== {e, e, e} || oVGA_BLANK_N !== act(p)) begin
        failures++;
        $display("FAIL pixel t=%0d got=%h/%h/%h bl=%b exp=%h bl=%b", t, oVGA_R, oVGA_G, oVGA_B, oVGA_BLANK_N, e, act(p));
      end
      checks++;
      if (oFIFO_RDREQ !== act(t) || oUNDERFLOW !== 1'b0) begin
        failures++;
        $display("FAIL rdreq_run t=%0d got=%b uf=%b exp=%b uf=0", t, oFIFO_RDREQ, oUNDERFLOW, act(t));
      end
    end
  endtask

  task automatic test_sync_timing();
    int p, hs_r, vs_r, bl_r;
    bit hs_p, vs_p, bl_p, ehs, evs, efd;
    do_reset();
    hs_r = -1; vs_r = -1; bl_r = -1;
    hs_p = 0; vs_p = 0; bl_p = 0;
    while (t < 2 * FT + HT) begin
      step();
      p = t - 1;
      ehs = h_of(p) >= HA + HFP && h_of(p) < HA + HFP + HSY;
      evs = v_of(p) >= VA + VFP && v_of(p) < VA + VFP + VSY;
      efd = v_of(t) == VA && h_of(t) == 0;
      checks++;
      if (oVGA_HS !== ehs || oVGA_VS !== evs || oVGA_BLANK_N !== act(p) || oFRAME_DONE !== efd) begin
        failures++;
        $display("FAIL sync_pos t=%0d got=%b%b%b%b exp=%b%b%b%b", t, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFRAME_DONE, ehs, evs, act(p), efd);
      end
      if (oVGA_HS && !hs_p) begin
        if (hs_r >= 0) begin
          checks++;
          if (t - hs_r != HT) begin failures++; $display("FAIL hs_period got=%0d exp=%0d", t - hs_r, HT); end
        end
        hs_r = t;
      end
      if (!oVGA_HS && hs_p) begin
        checks++;
        if (t - hs_r != HSY) begin failures++; $display("FAIL hs_width got=%0d exp=%0d", t - hs_r, HSY); end
      end
      if (oVGA_VS && !vs_p) begin
        if (vs_r >= 0) begin
          checks++;
          if (t - vs_r != FT) begin failures++; $display("FAIL vs_period got=%0d exp=%0d", t - vs_r, FT); end
        end
        vs_r = t;
      end
      if (!oVGA_VS && vs_p) begin
        checks++;
        if (t - vs_r != VSY * HT) begin failures++; $display("FAIL vs_width got=%0d exp=%0d", t - vs_r, VSY * HT); end
      end
      if (oVGA_BLANK_N && !bl_p) bl_r = t;
      if (!oVGA_BLANK_N && bl_p) begin
        checks++;
        if (t - bl_r != HA) begin failures++; $display("FAIL blank_width got=%0d exp=%0d", t - bl_r, HA); end
      end
      hs_p = oVGA_HS; vs_p = oVGA_VS; bl_p = oVGA_BLANK_N;
    end
    checks++;
    if (oUNDERFLOW !== 1'b0 || vs_r < 0) begin
      failures++;
      $display("FAIL sync_underflow got=%b vs_seen=%0d exp=0", oUNDERFLOW, vs_r);
    end
  endtask

  task automatic test_underflow();
    int n_ok, p;
    bit uf_exp, fz;
    logic [7:0] e;
    do_reset();
    force_en = 1'b1;
    n_ok = 0;
    uf_exp = 1'b0;
    while (t < 8 * HT) begin
      step();
      p = t - 1;
      fz = forced(p);
      e = (act(p) && !fz) ? n_ok[7:0] : 8'h00;
      if (act(p) && fz) uf_exp = 1'b1;
      if (act(p) && !fz) n_ok++;
      checks++;
      if ({oVGA_R, oVGA_G, oVGA_B} !== {e, e, e}) begin
        failures++;
        $display("FAIL uf_pixel t=%0d got=%h exp=%h", t, oVGA_R, e);
      end
      checks++;
      if (oUNDERFLOW !== uf_exp) begin
        failures++;
        $display("FAIL uf_flag t=%0d got=%b exp=%b", t, oUNDERFLOW, uf_exp);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (h_of(t) != 80 && guard < HT) begin step(); guard++; end
    checks++;
    if (h_of(t) != 80 || oUNDERFLOW !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup got=h%0d uf=%b exp=h80 uf=1", h_of(t), oUNDERFLOW);
    end
    iRST = 1'b1;
    step();
    fifo.delete();
    checks++;
    if (outs() !== 44'h0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h exp=0", outs());
    end
    iRST = 1'b0;
    for (int i = 0; i < HA + 2; i++) begin
      step();
      checks++;
      if (oVGA_LOAD_TO_FIFO_REQ !== (t == HA + 1) || oVGA_LINE_TO_LOAD !== 13'd0 || oUNDERFLOW !== 1'b0) begin
        failures++;
        $display("FAIL midrst_restart t=%0d got=%b/%0d uf=%b exp=%b/0 uf=0", t, oVGA_LOAD_TO_FIFO_REQ, oVGA_LINE_TO_LOAD, oUNDERFLOW, t == HA + 1);
      end
    end
  endtask

  task automatic test_drain();
    int dcnt;
    do_reset();
    extra = 37;
    dcnt = 0;
    while (t < HT + FT + 1) begin
      if (oFIFO_RDREQ === 1'b1 && !act(t)) dcnt++;
      step();
    end
    checks++;
    if (dcnt != 37) begin failures++; $display("FAIL drain_reads got=%0d exp=37", dcnt); end
    checks++;
    if (oVGA_R !== pix(1, 0, 0) || oVGA_BLANK_N !== 1'b1) begin
      failures++;
      $display("FAIL drain_first_pixel got=%h bl=%b exp=%h bl=1", oVGA_R, oVGA_BLANK_N, pix(1, 0, 0));
    end
    checks++;
    if (oUNDERFLOW !== 1'b0) begin failures++; $display("FAIL drain_underflow got=%b exp=0", oUNDERFLOW); end
    extra = 0;
  endtask

  task automatic test_drain_timeout();
    do_reset();
    extra = 2000;
    while (t < FT) step();
    checks++;
    if (oUNDERFLOW !== 1'b0) begin failures++; $display("FAIL timeout_pre got=%b exp=0", oUNDERFLOW); end
    step();
    checks++;
    if (oUNDERFLOW !== 1'b1 || oFIFO_RDREQ !== 1'b0) begin
      failures++;
      $display("FAIL timeout_post got=uf%b rd%b exp=uf1 rd0", oUNDERFLOW, oFIFO_RDREQ);
    end
    extra = 0;
  endtask

  initial begin
    iRST = 1'b1;
    iFIFO_EMPTY = 1'b1;
    iFIFO_RDATA = 8'h00;
    test_reset();
    test_first_request();
    test_pixels();
    test_sync_timing();
    test_underflow();
    test_mid_reset();
    test_drain();
    test_drain_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
